// File: rtl/ddr3_phase_step_ctrl_if.sv
// Request/status bus between the write-leveling FSM (master) and the
// PLL phase-step controller (slave).
interface ddr3_phase_step_ctrl_if #(
    parameter int PW = 4
);
    logic          req_valid;
    logic          req_ready;
    logic          req_abs;
    logic          req_dir;
    logic [PW-1:0] req_val;
    logic          busy;
    logic          move_done;
    logic          move_err;
    logic [PW-1:0] phase_pos;

    modport master (
        output req_valid, req_abs, req_dir, req_val,
        input  req_ready, busy, move_done, move_err, phase_pos
    );

    modport slave (
        input  req_valid, req_abs, req_dir, req_val,
        output req_ready, busy, move_done, move_err, phase_pos
    );
endinterface

// File: rtl/ddr3_phase_step_ctrl.sv
// Drives the PLL dynamic phase-shift port one step at a time and tracks
// the resulting write-DQS phase position modulo PHASE_STEPS.
//
// state       | meaning
// S_IDLE      | waiting for a request; ready when PLL locked
// S_SETUP     | direction driven, one cycle before the step edge
// S_STEP_HI   | phase_step high for STEP_HIGH_CLKS cycles
// S_WAIT_DONE | waiting for phase_done, bounded by DONE_TIMEOUT
// S_SETTLE    | idle gap after a completed step
module ddr3_phase_step_ctrl #(
    parameter int PHASE_STEPS    = 16,
    parameter int INIT_POS       = 0,
    parameter int STEP_HIGH_CLKS = 4,
    parameter int SETTLE_CLKS    = 8,
    parameter int USE_DONE       = 1,
    parameter int DONE_TIMEOUT   = 1024,
    localparam int PW            = $clog2(PHASE_STEPS)
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_pll_locked,
    input  logic i_phase_done,
    output logic o_phase_step,
    output logic o_phase_updn,
    ddr3_phase_step_ctrl_if.slave req_if
);

    localparam int TW = $clog2(DONE_TIMEOUT + STEP_HIGH_CLKS + SETTLE_CLKS + 1);
    localparam logic [TW-1:0] STEP_LOAD   = TW'(STEP_HIGH_CLKS - 1);
    localparam logic [TW-1:0] DONE_LOAD   = TW'(DONE_TIMEOUT - 1);
    localparam logic [TW-1:0] SETTLE_LOAD = TW'((SETTLE_CLKS > 0) ? SETTLE_CLKS - 1 : 0);
    localparam logic [PW:0]   HALF        = (PW+1)'(PHASE_STEPS / 2);
    localparam logic [PW-1:0] POS_INIT    = PW'(INIT_POS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STEP_HI,
        S_WAIT_DONE,
        S_SETTLE
    } state_t;

    state_t        r_state, w_state_nx;
    logic [PW-1:0] r_pos, w_pos_nx;
    logic [PW-1:0] r_remain, w_remain_nx;
    logic [TW-1:0] r_tmr, w_tmr_nx;
    logic          r_updn, w_updn_nx;
    logic          r_step;
    logic          r_done, w_done_nx;
    logic          r_err, w_err_nx;

    logic          w_ready;
    logic          w_accept;
    logic [PW-1:0] w_diff;
    logic [PW-1:0] w_n;
    logic          w_dir;
    logic [PW-1:0] w_pos_stepped;

    assign w_ready  = (r_state == S_IDLE) && i_pll_locked;
    assign w_accept = req_if.req_valid && w_ready;
    assign w_diff   = req_if.req_val - r_pos;
    assign w_pos_stepped = r_updn ? (r_pos + PW'(1)) : (r_pos - PW'(1));

    // Absolute moves take the shorter way round; a half-turn tie goes up.
    always_comb begin
        w_n   = req_if.req_val;
        w_dir = req_if.req_dir;
        if (req_if.req_abs) begin
            if ({1'b0, w_diff} <= HALF) begin
                w_n   = w_diff;
                w_dir = 1'b1;
            end else begin
                w_n   = -w_diff;
                w_dir = 1'b0;
            end
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_pos_nx    = r_pos;
        w_remain_nx = r_remain;
        w_tmr_nx    = r_tmr;
        w_updn_nx   = r_updn;
        w_done_nx   = 1'b0;
        w_err_nx    = r_err;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_err_nx = 1'b0;
                    if (w_n == '0) begin
                        w_done_nx = 1'b1;
                    end else begin
                        w_state_nx  = S_SETUP;
                        w_remain_nx = w_n;
                        w_updn_nx   = w_dir;
                    end
                end
            end
            S_SETUP: begin
                w_state_nx = S_STEP_HI;
                w_tmr_nx   = STEP_LOAD;
            end
            S_STEP_HI: begin
                if (r_tmr != '0) begin
                    w_tmr_nx = r_tmr - TW'(1);
                end else if (USE_DONE != 0) begin
                    w_state_nx = S_WAIT_DONE;
                    w_tmr_nx   = DONE_LOAD;
                end else begin
                    w_state_nx  = S_SETTLE;
                    w_tmr_nx    = SETTLE_LOAD;
                    w_pos_nx    = w_pos_stepped;
                    w_remain_nx = r_remain - PW'(1);
                end
            end
            S_WAIT_DONE: begin
                if (i_phase_done) begin
                    w_state_nx  = S_SETTLE;
                    w_tmr_nx    = SETTLE_LOAD;
                    w_pos_nx    = w_pos_stepped;
                    w_remain_nx = r_remain - PW'(1);
                end else if (r_tmr == '0) begin
                    w_state_nx = S_IDLE;
                    w_err_nx   = 1'b1;
                    w_done_nx  = 1'b1;
                end else begin
                    w_tmr_nx = r_tmr - TW'(1);
                end
            end
            S_SETTLE: begin
                if (r_tmr != '0) begin
                    w_tmr_nx = r_tmr - TW'(1);
                end else if (r_remain == '0) begin
                    w_state_nx = S_IDLE;
                    w_done_nx  = 1'b1;
                end else begin
                    w_state_nx = S_SETUP;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase

        // The PLL restarts at its default phase whenever lock is lost.
        if (!i_pll_locked) begin
            w_pos_nx = POS_INIT;
            if (r_state != S_IDLE) begin
                w_state_nx = S_IDLE;
                w_err_nx   = 1'b1;
                w_done_nx  = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_pos    <= POS_INIT;
            r_remain <= '0;
            r_tmr    <= '0;
            r_updn   <= 1'b1;
            r_step   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_pos    <= w_pos_nx;
            r_remain <= w_remain_nx;
            r_tmr    <= w_tmr_nx;
            r_updn   <= w_updn_nx;
            r_step   <= (w_state_nx == S_STEP_HI);
            r_done   <= w_done_nx;
            r_err    <= w_err_nx;
        end
    end

    assign o_phase_step     = r_step;
    assign o_phase_updn     = r_updn;
    assign req_if.req_ready = w_ready;
    assign req_if.busy      = (r_state != S_IDLE);
    assign req_if.move_done = r_done;
    assign req_if.move_err  = r_err;
    assign req_if.phase_pos = r_pos;

endmodule
